// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings and per-state control decode for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } alu_op_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_t    alu_op;
  } ctrl_t;
  // Anything not named for a state stays 0, which also covers the illegal encodings.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = AOP_FUNCT; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = AOP_SUB; c.pc_src = 2'b01; c.branch = 1'b1; end
      S_ADDIEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps alu_op and R-type funct to the 3-bit ALU control code
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FNW = 6
) (
  input  alu_op_t        alu_op_i,
  input  logic [FNW-1:0] funct_i,
  output logic [2:0]     alu_control_o
);
  logic [2:0] fn_ctrl;
  always_comb begin
    fn_ctrl = funct_i == FN_SUB ? ALU_SUB :
              funct_i == FN_AND ? ALU_AND :
              funct_i == FN_OR  ? ALU_OR  :
              funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
    alu_control_o = alu_op_i == AOP_SUB   ? ALU_SUB :
                    alu_op_i == AOP_FUNCT ? fn_ctrl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM sequencing one MIPS instruction at a time
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode_i,
  input  logic [FNW-1:0] funct_i,
  input  logic           zero_i,
  output logic           pc_en_o,
  output logic           iord_o,
  output logic           mem_write_o,
  output logic           ir_write_o,
  output logic           reg_write_o,
  output logic           reg_dst_o,
  output logic           mem_to_reg_o,
  output logic           alu_src_a_o,
  output logic [1:0]     alu_src_b_o,
  output logic [1:0]     pc_src_o,
  output logic [2:0]     alu_control_o,
  output logic [3:0]     state_o
);
  state_t state, nxt;
  ctrl_t  ctrl;
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = (opcode_i == OP_LW || opcode_i == OP_SW) ? S_MEMADR :
                      opcode_i == OP_R    ? S_EXECUTE :
                      opcode_i == OP_BEQ  ? S_BRANCH  :
                      opcode_i == OP_ADDI ? S_ADDIEX  :
                      opcode_i == OP_J    ? S_JUMP    : S_FETCH;
      S_MEMADR:  nxt = opcode_i == OP_LW ? S_MEMREAD :
                       opcode_i == OP_SW ? S_MEMWRITE : S_FETCH;
      S_MEMREAD: nxt = S_MEMWB;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end
  // Controls are registered alongside the state so they are a glitch-free copy of its decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= nxt;
      ctrl  <= state_ctrl(nxt);
    end
  end
  alu_decoder #(.FNW(FNW)) u_alu_decoder (
    .alu_op_i      (ctrl.alu_op),
    .funct_i       (funct_i),
    .alu_control_o (alu_control_o)
  );
  // Architectural enables are masked while reset is held so nothing commits during reset.
  assign pc_en_o      = reset & (ctrl.pc_write | (ctrl.branch & zero_i));
  assign ir_write_o   = reset & ctrl.ir_write;
  assign mem_write_o  = reset & ctrl.mem_write;
  assign reg_write_o  = reset & ctrl.reg_write;
  assign iord_o       = ctrl.iord;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign pc_src_o     = ctrl.pc_src;
  assign state_o      = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-instruction sequences checked against hand-built output vectors
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode_i = '0;
  logic [5:0] funct_i = '0;
  logic       zero_i = 1'b0;
  logic       pc_en_o, iord_o, mem_write_o, ir_write_o, reg_write_o;
  logic       reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_control_o;
  logic [3:0] state_o;
  int checks = 0;
  int failures = 0;
  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode_i      (opcode_i),
    .funct_i       (funct_i),
    .zero_i        (zero_i),
    .pc_en_o       (pc_en_o),
    .iord_o        (iord_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_write_o   (reg_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .pc_src_o      (pc_src_o),
    .alu_control_o (alu_control_o),
    .state_o       (state_o)
  );
  always #5 clk = ~clk;
  // {state | pc_en iord mem_write ir_write | reg_write reg_dst mem_to_reg alu_src_a | alu_src_b | pc_src | alu_control}
  logic [18:0] obs;
  assign obs = {state_o, pc_en_o, iord_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
                mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_control_o};
  localparam logic [18:0] V_RST      = 19'b0000_0000_0000_01_00_010;
  localparam logic [18:0] V_FETCH    = 19'b0000_1001_0000_01_00_010;
  localparam logic [18:0] V_DECODE   = 19'b0001_0000_0000_11_00_010;
  localparam logic [18:0] V_MEMADR   = 19'b0010_0000_0001_10_00_010;
  localparam logic [18:0] V_MEMREAD  = 19'b0011_0100_0000_00_00_010;
  localparam logic [18:0] V_MEMWB    = 19'b0100_0000_1010_00_00_010;
  localparam logic [18:0] V_MEMWRITE = 19'b0101_0110_0000_00_00_010;
  localparam logic [15:0] V_EXEC_HI  = 16'b0110_0000_0001_00_00;
  localparam logic [18:0] V_ALUWB    = 19'b0111_0000_1100_00_00_010;
  localparam logic [18:0] V_BR_TAKEN = 19'b1000_1000_0001_00_01_110;
  localparam logic [18:0] V_BR_NOT   = 19'b1000_0000_0001_00_01_110;
  localparam logic [18:0] V_ADDIEX   = 19'b1001_0000_0001_10_00_010;
  localparam logic [18:0] V_ADDIWB   = 19'b1010_0000_1000_00_00_010;
  localparam logic [18:0] V_JUMP     = 19'b1011_1000_0000_00_10_010;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    if (obs !== V_RST) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, V_RST); end
    checks++;
    zero_i = 1'b1;
    #1;
    if (obs !== V_RST) begin failures++; $display("FAIL reset_held_zero got=%b exp=%b", obs, V_RST); end
    checks++;
    zero_i = 1'b0;
    reset = 1'b1;
    #1;
    if (obs !== V_FETCH) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, V_FETCH); end
    checks++;
  endtask
  task automatic test_r_type();
    logic [5:0] fn [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110000};
    logic [2:0] alu [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    for (int j = 0; j < 6; j++) begin
      logic [18:0] e [4];
      e = '{V_FETCH, V_DECODE, {V_EXEC_HI, alu[j]}, V_ALUWB};
      opcode_i = 6'b000000;
      funct_i = fn[j];
      for (int i = 0; i < 4; i++) begin
        if (obs !== e[i]) begin failures++; $display("FAIL r_fn%b c%0d got=%b exp=%b", fn[j], i + 1, obs, e[i]); end
        checks++;
        step();
      end
    end
  endtask
  task automatic test_lw();
    logic [18:0] e [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
    opcode_i = 6'b100011;
    funct_i = 6'b100010;
    for (int i = 0; i < 5; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL lw c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      step();
    end
  endtask
  task automatic test_sw();
    logic [18:0] e [4] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE};
    opcode_i = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL sw c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      step();
    end
  endtask
  task automatic test_beq();
    opcode_i = 6'b000100;
    for (int t = 0; t < 2; t++) begin
      if (obs !== V_FETCH) begin failures++; $display("FAIL beq%0d fetch got=%b exp=%b", t, obs, V_FETCH); end
      checks++;
      step();
      zero_i = 1'b1;
      #1;
      if (obs !== V_DECODE) begin failures++; $display("FAIL beq%0d decode_zero got=%b exp=%b", t, obs, V_DECODE); end
      checks++;
      step();
      zero_i = (t == 0);
      #1;
      if (obs !== (t == 0 ? V_BR_TAKEN : V_BR_NOT)) begin
        failures++;
        $display("FAIL beq%0d branch got=%b exp=%b", t, obs, t == 0 ? V_BR_TAKEN : V_BR_NOT);
      end
      checks++;
      zero_i = (t != 0);
      #1;
      if (obs !== (t == 0 ? V_BR_NOT : V_BR_TAKEN)) begin
        failures++;
        $display("FAIL beq%0d branch_toggle got=%b exp=%b", t, obs, t == 0 ? V_BR_NOT : V_BR_TAKEN);
      end
      checks++;
      zero_i = 1'b0;
      step();
    end
  endtask
  task automatic test_addi();
    logic [18:0] e [4] = '{V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB};
    opcode_i = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL addi c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      step();
    end
  endtask
  task automatic test_jump();
    logic [18:0] e [3] = '{V_FETCH, V_DECODE, V_JUMP};
    opcode_i = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL j c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      step();
    end
  endtask
  task automatic test_unknown();
    logic [18:0] e [3] = '{V_FETCH, V_DECODE, V_FETCH};
    opcode_i = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL unknown c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      if (i < 2) step();
    end
  endtask
  task automatic test_reset_mid();
    logic [18:0] e [4] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD};
    opcode_i = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      if (obs !== e[i]) begin failures++; $display("FAIL rstmid c%0d got=%b exp=%b", i + 1, obs, e[i]); end
      checks++;
      if (i < 3) step();
    end
    reset = 1'b0;
    #1;
    if (obs !== V_RST) begin failures++; $display("FAIL rstmid_async got=%b exp=%b", obs, V_RST); end
    checks++;
    step();
    if (obs !== V_RST) begin failures++; $display("FAIL rstmid_held got=%b exp=%b", obs, V_RST); end
    checks++;
    reset = 1'b1;
    #1;
    if (obs !== V_FETCH) begin failures++; $display("FAIL rstmid_release got=%b exp=%b", obs, V_FETCH); end
    checks++;
    step();
    if (obs !== V_DECODE) begin failures++; $display("FAIL rstmid_restart got=%b exp=%b", obs, V_DECODE); end
    checks++;
  endtask
  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw();
    test_beq();
    test_addi();
    test_jump();
    test_unknown();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
